// File: rtl/conv_window_gen.sv
// ============================================================================
// Module      : conv_window_gen
// Description : Raster-stream 3x3 sliding-window generator with two line
//               buffers; emits every fully-populated window of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] win_00,
    output logic [DATA_W-1:0] win_01,
    output logic [DATA_W-1:0] win_02,
    output logic [DATA_W-1:0] win_10,
    output logic [DATA_W-1:0] win_11,
    output logic [DATA_W-1:0] win_12,
    output logic [DATA_W-1:0] win_20,
    output logic [DATA_W-1:0] win_21,
    output logic [DATA_W-1:0] win_22,
    output logic              win_valid,
    output logic              frame_done
);

    localparam int c_cw = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_rw = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_W - 1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_H - 1);

    logic [c_cw-1:0]   r_col;
    logic [c_rw-1:0]   r_row;
    logic [DATA_W-1:0] r_line_a [IMG_W];
    logic [DATA_W-1:0] r_line_b [IMG_W];
    logic [DATA_W-1:0] r_win    [3][3];
    logic              r_win_valid;
    logic              r_frame_done;

    logic [c_cw-1:0]   w_col;
    logic [c_rw-1:0]   w_row;
    logic [c_cw-1:0]   w_col_next;
    logic [c_rw-1:0]   w_row_next;
    logic [DATA_W-1:0] w_a_out;
    logic [DATA_W-1:0] w_b_out;
    logic              w_in_window;
    logic              w_is_last;

    // sof overrides the counters so the accepted beat lands on the origin
    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_col_next = w_col + c_cw'(1);
        w_row_next = w_row;
        if (w_col == c_col_last) begin
            w_col_next = '0;
            w_row_next = (w_row == c_row_last) ? '0 : w_row + c_rw'(1);
        end
    end

    assign w_a_out     = r_line_a[IMG_W-1];
    assign w_b_out     = r_line_b[IMG_W-1];
    assign w_in_window = (w_row >= c_rw'(2)) && (w_col >= c_cw'(2));
    assign w_is_last   = (w_row == c_row_last) && (w_col == c_col_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                r_line_a[i] <= '0;
                r_line_b[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_win_valid  <= pixel_valid && w_in_window;
            r_frame_done <= pixel_valid && w_in_window && w_is_last;
            if (pixel_valid) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
                r_line_a[0] <= pixel_in;
                r_line_b[0] <= w_a_out;
                for (int i = 1; i < IMG_W; i++) begin
                    r_line_a[i] <= r_line_a[i-1];
                    r_line_b[i] <= r_line_b[i-1];
                end
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_b_out;
                r_win[1][2] <= w_a_out;
                r_win[2][2] <= pixel_in;
            end
        end
    end

    assign win_00     = r_win[0][0];
    assign win_01     = r_win[0][1];
    assign win_02     = r_win[0][2];
    assign win_10     = r_win[1][0];
    assign win_11     = r_win[1][1];
    assign win_12     = r_win[1][2];
    assign win_20     = r_win[2][0];
    assign win_21     = r_win[2][1];
    assign win_22     = r_win[2][2];
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Self-checking bench for conv_window_gen on a 4x4 frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       sof;
    logic [7:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
    logic       win_valid;
    logic       frame_done;
    logic [71:0] dut_taps;

    int          n_vec = 0;
    int          n_bad = 0;
    int          mr, mc;
    logic [7:0]  img [H][W];
    logic        exp_v, exp_fd;
    logic [71:0] exp_taps;
    logic [71:0] last_win;

    always #5 clk = ~clk;

    assign dut_taps = {win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22};

    conv_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
        .win_00(win_00), .win_01(win_01), .win_02(win_02),
        .win_10(win_10), .win_11(win_11), .win_12(win_12),
        .win_20(win_20), .win_21(win_21), .win_22(win_22),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    // Reference: remember the frame as a 2-D image; a window is the 3x3 patch
    // ending at the current raster position once it exists in this frame.
    task automatic beat(input logic [7:0] pix, input logic s);
        pixel_in    = pix;
        pixel_valid = 1'b1;
        sof         = s;
        if (s) begin mr = 0; mc = 0; end
        img[mr][mc] = pix;
        exp_v  = (mr >= 2) && (mc >= 2);
        exp_fd = (mr == H-1) && (mc == W-1);
        if (exp_v) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_taps[(8-(r*3+c))*8 +: 8] = img[mr-2+r][mc-2+c];
            last_win = exp_taps;
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
    endtask

    task automatic idle_cycle();
        pixel_valid = 1'b0;
        sof         = 1'b0;
        @(posedge clk); #1;
        exp_v  = 1'b0;
        exp_fd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pixel_valid = 1'b0; sof = 1'b0; pixel_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || dut_taps !== 72'h0) begin
            n_bad++;
            $display("FAIL reset outputs: got v=%b fd=%b taps=%h, want all zero", win_valid, frame_done, dut_taps);
        end
        reset = 1'b0; mr = 0; mc = 0;
        idle_cycle();
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || dut_taps !== 72'h0) begin
            n_bad++;
            $display("FAIL post-reset idle: got v=%b fd=%b taps=%h, want all zero", win_valid, frame_done, dut_taps);
        end
    endtask

    task automatic test_basic();
        int nw = 0, nf = 0;
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), i == 1);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL basic flags px%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL basic taps px%0d: got %h want %h", i, dut_taps, exp_taps);
                end
            end
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) nf++;
        end
        n_vec++;
        if (nw !== 4 || nf !== 1) begin
            n_bad++;
            $display("FAIL basic counts: got win=%0d fd=%0d want win=4 fd=1", nw, nf);
        end
    endtask

    task automatic test_gaps();
        int nw = 0, nf = 0;
        logic held;
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), i == 1);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL gaps flags px%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL gaps taps px%0d: got %h want %h", i, dut_taps, exp_taps);
                end
            end
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) nf++;
            held = exp_v;
            for (int g = 0; g < 3; g++) begin
                idle_cycle();
                n_vec++;
                if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gaps idle flags px%0d: got v=%b fd=%b want 0 0", i, win_valid, frame_done);
                end
                if (held) begin
                    n_vec++;
                    if (dut_taps !== last_win) begin
                        n_bad++;
                        $display("FAIL gaps hold px%0d: got %h want %h", i, dut_taps, last_win);
                    end
                end
            end
        end
        n_vec++;
        if (nw !== 4 || nf !== 1) begin
            n_bad++;
            $display("FAIL gaps counts: got win=%0d fd=%0d want win=4 fd=1", nw, nf);
        end
    endtask

    task automatic test_back_to_back();
        int nw = 0, nf = 0;
        logic first2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            int p = (i < 16) ? i + 1 : i + 85;
            beat(8'(p), (i == 0) || (i == 16));
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL b2b flags px%0d: got v=%b fd=%b want v=%b fd=%b", p, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL b2b taps px%0d: got %h want %h", p, dut_taps, exp_taps);
                end
            end
            if (i >= 16 && win_valid === 1'b1 && first2) begin
                first2 = 1'b0;
                n_vec++;
                if (dut_taps !== 72'h65_66_67_69_6A_6B_6D_6E_6F) begin
                    n_bad++;
                    $display("FAIL b2b first window: got %h want 6566676 96A6B6D6E6F", dut_taps);
                end
            end
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) nf++;
        end
        n_vec++;
        if (nw !== 8 || nf !== 2) begin
            n_bad++;
            $display("FAIL b2b counts: got win=%0d fd=%0d want win=8 fd=2", nw, nf);
        end
    endtask

    task automatic test_mid_reset();
        int nw = 0, nf = 0;
        for (int i = 1; i <= 10; i++) begin
            beat(8'(i), i == 1);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL mreset pre flags px%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || dut_taps !== 72'h0) begin
            n_bad++;
            $display("FAIL mreset async: got v=%b fd=%b taps=%h want all zero", win_valid, frame_done, dut_taps);
        end
        @(posedge clk); #1;
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || dut_taps !== 72'h0) begin
            n_bad++;
            $display("FAIL mreset held: got v=%b fd=%b taps=%h want all zero", win_valid, frame_done, dut_taps);
        end
        reset = 1'b0; mr = 0; mc = 0;
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), 1'b0);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL mreset flags px%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL mreset taps px%0d: got %h want %h", i, dut_taps, exp_taps);
                end
            end
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) nf++;
        end
        n_vec++;
        if (nw !== 4 || nf !== 1) begin
            n_bad++;
            $display("FAIL mreset counts: got win=%0d fd=%0d want win=4 fd=1", nw, nf);
        end
    endtask

    task automatic test_signed();
        logic [7:0] seq [3] = '{8'h80, 8'h7F, 8'hFF};
        logic first = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] p = (i < 3) ? seq[i] : 8'($urandom);
            beat(p, i == 0);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL signed flags beat%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL signed taps beat%0d: got %h want %h", i, dut_taps, exp_taps);
                end
                if (first) begin
                    first = 1'b0;
                    n_vec++;
                    if (win_00 !== 8'h80 || win_01 !== 8'h7F || win_02 !== 8'hFF) begin
                        n_bad++;
                        $display("FAIL signed extremes: got %h %h %h want 80 7f ff", win_00, win_01, win_02);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        int nw = 0, nf = 0;
        for (int i = 1; i <= 6; i++) begin
            beat(8'(i), i == 1);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL msof partial flags px%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
        end
        for (int i = 0; i < 16; i++) begin
            beat(8'(i + 21), i == 0);
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL msof flags beat%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL msof taps beat%0d: got %h want %h", i, dut_taps, exp_taps);
                end
            end
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) nf++;
        end
        n_vec++;
        if (nw !== 4 || nf !== 1) begin
            n_bad++;
            $display("FAIL msof counts: got win=%0d fd=%0d want win=4 fd=1", nw, nf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            beat(8'($urandom), ($urandom_range(0, 19) == 0));
            n_vec++;
            if (win_valid !== exp_v || frame_done !== exp_fd) begin
                n_bad++;
                $display("FAIL random flags beat%0d: got v=%b fd=%b want v=%b fd=%b", i, win_valid, frame_done, exp_v, exp_fd);
            end
            if (exp_v) begin
                n_vec++;
                if (dut_taps !== exp_taps) begin
                    n_bad++;
                    $display("FAIL random taps beat%0d: got %h want %h", i, dut_taps, exp_taps);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                idle_cycle();
                n_vec++;
                if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL random idle flags beat%0d: got v=%b fd=%b want 0 0", i, win_valid, frame_done);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; pixel_valid = 1'b0; sof = 1'b0; pixel_in = 8'h00;
        exp_v = 1'b0; exp_fd = 1'b0; exp_taps = '0; last_win = '0;
        mr = 0; mc = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_signed();
        test_mid_sof();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Upstream feeder for the 3x3 Conv2D_ReLU stage. It accepts a raster-order pixel stream of one IMG_H x IMG_W feature map, one pixel per accepted beat, and buffers two full lines. It emits every fully-populated 3x3 window (valid convolution, no padding) as nine parallel signed taps. The taps connect directly to the input_feature_map_rc ports of the conv stage.

Parameters:
DATA_W, 8, pixel width in bits (signed two's complement)
IMG_W, 8, pixels per line; legal range 3..256
IMG_H, 8, lines per frame; legal range 3..256

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pixel_in  input  DATA_W  signed input pixel
pixel_valid  input  1  pixel_in is accepted this cycle when high
sof  input  1  start of frame; qualified by pixel_valid; forces the accepted pixel to position (0,0)
win_00..win_22  output  DATA_W each (9 ports)  window taps; win_rc = pixel(row-2+r, col-2+c)
win_valid  output  1  window taps hold a new complete window this cycle
frame_done  output  1  one-cycle pulse marking the last window of a frame

Behaviour:
- Reset (async assert, sync-released use): row/col counters=0, both line buffers=0, 3x3 window regs=0, all win_* = 0, win_valid=0, frame_done=0.
- Position tracking: col counts 0..IMG_W-1, then wraps to 0 and increments row. row counts 0..IMG_H-1, then wraps to 0, so the next frame starts automatically.
- Counters advance only on accepted beats (pixel_valid=1). With pixel_valid=0, all state and win_* hold, and win_valid=0 and frame_done=0.
- sof=1 with pixel_valid=1: the beat is treated as (0,0) regardless of the counters. After it, col=1 and row=0 (col=0, row=1 if IMG_W=1, which is illegal). Line buffer contents are not cleared. sof with pixel_valid=0 is ignored.
- Line buffers: two IMG_W-deep shift lines. Line A holds row-1 and line B holds row-2 at the current column. Each accepted beat shifts pixel_in into A and A's output into B.
- Window shift: each accepted beat shifts the 3x3 register left by one column. The new right column is {B out, A out, pixel_in}, mapped to {win_02, win_12, win_22}.
- Output: registered, latency 1 cycle. win_valid=1 in the cycle after an accepted beat at (row>=2, col>=2). win_22 is that pixel and win_00 is pixel (row-2, col-2).
- Taps are only meaningful when win_valid=1. They update on every accepted beat and hold otherwise.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No windows are emitted for beats at col<2 or row<2; stale data from the previous line or frame is never flagged valid.
- frame_done=1 coincident with the win_valid produced by the beat at (IMG_H-1, IMG_W-1).
- Back-to-back frames need no idle cycle. A mid-frame sof abandons the partial frame; no frame_done is produced for it.
- No backpressure, because the downstream stage is always ready. Data is a pure pass-through with no arithmetic, so signs are preserved bit-exactly.
- Reset asserted mid-frame: the next accepted pixel is (0,0) and no window is emitted until row 2, col 2 of the new frame.

Test Plan:
1. IMG_W=IMG_H=4; stream 1..16 continuously, sof on the first beat. Required: exactly 4 win_valid pulses.
   - 1 cycle after pixel 11: window 1,2,3/5,6,7/9,10,11.
   - After 12: 2,3,4/6,7,8/10,11,12.
   - After 15: 5,6,7/9,10,11/13,14,15.
   - After 16: 6,7,8/10,11,12/14,15,16, with frame_done=1 only on this pulse.
2. Same stream with pixel_valid low for 3 cycles between every beat. Required: identical windows in the same order; win_valid and frame_done each high for one cycle per window; taps hold during gaps.
3. Two frames back-to-back (1..16 then 101..116, sof on 101). Required: the second frame's first window is 101,102,103/105,106,107/109,110,111, with no window from mixed-frame data.
4. Assert reset after pixel 10 of frame 1, then restart with 1..16. Required: all outputs are 0 during reset, and the window sequence is identical to scenario 1.
5. Pixels -128,127,-1,... (signed extremes), 4x4. Required: taps equal the inputs bit-exactly, e.g. win_00=-128 (8'h80) in the first window.
6. sof asserted at pixel 7 of a frame, then 16 beats. Required: exactly 4 windows, all aligned to the new frame origin, and a single frame_done.
